branch_resolve_unit: RTL and testbench

Resolution-side end of the 2-bit branch predictor. The fetch stage queries the predictor table. This block receives resolved branch outcomes from EX and compares each against the prediction carried down the pipe. It updates the owning counter table with a read-modify-write, and issues a one-cycle flush plus redirect PC on a mispredict. It owns the branch history table (BHT) and serves the fetch-side lookup read port.

---
 rtl/branch_resolve_unit_pkg.sv | 40 ++++
 rtl/bht_sat_counter.sv | 15 +
 rtl/branch_resolve_unit.sv | 119 +++++++++++
 tb/tb_branch_resolve_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared predictor types and constants for the branch resolution slice.
package branch_resolve_unit_pkg;

   localparam int RISC_V_DATA_WIDTH = 64;
   localparam int INST_BYTE_WIDTH   = 4;
   localparam int BHT_ENTRIES       = 64;
   localparam int BHT_INDEX_WIDTH   = 6;

   // 2-bit predictor counter; the taken states share the MSB = 0.
   typedef enum logic [1:0] {
      predict_taken_strong     = 2'b00,
      predict_taken_weak       = 2'b01,
      predict_not_taken_strong = 2'b10,
      predict_not_taken_weak   = 2'b11
   } bpredictor_state_t;

   typedef enum logic {
      IDLE   = 1'b0,
      UPDATE = 1'b1
   } resolve_state_t;

   // Saturating step of one counter toward the observed outcome.
   function automatic bpredictor_state_t bht_next_state(bpredictor_state_t s, logic taken);
      bpredictor_state_t n;
      n = s;
      case (s)
         predict_not_taken_strong: n = taken ? predict_not_taken_weak   : predict_not_taken_strong;
         predict_not_taken_weak:   n = taken ? predict_taken_weak       : predict_not_taken_strong;
         predict_taken_weak:       n = taken ? predict_taken_strong     : predict_not_taken_weak;
         predict_taken_strong:     n = taken ? predict_taken_strong     : predict_taken_weak;
         default:                  n = predict_not_taken_weak;
      endcase
      return n;
   endfunction

   function automatic logic bht_is_taken(bpredictor_state_t s);
      return (s == predict_taken_strong) || (s == predict_taken_weak);
   endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// Next-state logic for a single 2-bit branch history counter.
module bht_sat_counter
   import branch_resolve_unit_pkg::*;
(
   input  bpredictor_state_t state,
   input  logic              taken,
   output bpredictor_state_t state_next
);

   // Pure combinational step; the caller owns the storage.
   always_comb begin
      state_next = bht_next_state(state, taken);
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branch outcomes against fetch predictions, maintains the BHT
// with a two-cycle read-modify-write and issues a one-cycle flush/redirect.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int BHT_ENTRIES     = branch_resolve_unit_pkg::BHT_ENTRIES,
   parameter int BHT_INDEX_WIDTH = branch_resolve_unit_pkg::BHT_INDEX_WIDTH,
   parameter int PC_WIDTH        = RISC_V_DATA_WIDTH,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PC_WIDTH-1:0]  lookup_pc,
   output logic                 lookup_taken,
   input  logic                 res_valid,
   output logic                 res_ready,
   input  logic [PC_WIDTH-1:0]  res_pc,
   input  logic                 res_taken,
   input  logic                 res_pred_taken,
   input  logic [PC_WIDTH-1:0]  res_target,
   output logic                 flush,
   output logic [PC_WIDTH-1:0]  redirect_pc,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   localparam int IDX_LSB = $clog2(INST_BYTE_WIDTH);

   resolve_state_t             state, state_next;
   bpredictor_state_t          bht [BHT_ENTRIES];
   bpredictor_state_t          lat_entry, entry_next;
   logic [BHT_INDEX_WIDTH-1:0] lookup_idx, res_idx, lat_idx;
   logic                       lat_taken;
   logic                       mispredict_q;
   logic                       accept;
   logic                       unused_lookup_bits;

   assign lookup_idx = lookup_pc[IDX_LSB +: BHT_INDEX_WIDTH];
   assign res_idx    = res_pc[IDX_LSB +: BHT_INDEX_WIDTH];

   // Only the index field of the fetch PC matters; aliasing is intended.
   assign unused_lookup_bits = ^{lookup_pc[PC_WIDTH-1:IDX_LSB+BHT_INDEX_WIDTH],
                                 lookup_pc[IDX_LSB-1:0]};

   bht_sat_counter u_sat_counter (
      .state      (lat_entry),
      .taken      (lat_taken),
      .state_next (entry_next)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: accept in IDLE, always return from UPDATE.
   always_comb begin
      // NOTE: default assignment first so no path leaves the output unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (res_valid) state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: handshake, gated flush and fetch-side prediction.
   always_comb begin
      res_ready    = (state == IDLE) && !rst;
      accept       = res_valid && res_ready;
      flush        = (state == UPDATE) && mispredict_q && !rst;
      lookup_taken = bht_is_taken(bht[lookup_idx]);
   end

   // Latch the resolution and precompute the redirect at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_idx      <= '0;
         lat_taken    <= 1'b0;
         lat_entry    <= predict_not_taken_weak;
         mispredict_q <= 1'b0;
         redirect_pc  <= '0;
      end else begin
         mispredict_q <= accept && (res_taken != res_pred_taken);
         if (accept) begin
            lat_idx     <= res_idx;
            lat_taken   <= res_taken;
            lat_entry   <= bht[res_idx];
            redirect_pc <= res_taken ? res_target : res_pc + PC_WIDTH'(INST_BYTE_WIDTH);
         end
      end
   end

   // Write back the stepped counter at the end of UPDATE.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the table must power up in a known prediction state, so every entry is reset here.
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= predict_not_taken_weak;
      end else if (state == UPDATE) begin
         bht[lat_idx] <= entry_next;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (accept && (branch_count != '1))
            branch_count <= branch_count + CNT_WIDTH'(1);
         if (flush && (mispredict_count != '1))
            mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios plus random resolutions against a
// counter-value model of the predictor table.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] lookup_pc;
   logic        lookup_taken;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_pc;
   logic        res_taken;
   logic        res_pred_taken;
   logic [63:0] res_target;
   logic        flush;
   logic [63:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Model: strength 0..3 per entry (0 = strongly not taken, 3 = strongly taken).
   int          tbl [64];
   longint      exp_bc;
   longint      exp_mc;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk              (clk),
      .rst              (rst),
      .lookup_pc        (lookup_pc),
      .lookup_taken     (lookup_taken),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_pred_taken   (res_pred_taken),
      .res_target       (res_target),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [63:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) tbl[i] = 1;
      exp_bc = 0;
      exp_mc = 0;
   endtask

   task automatic check_lookup(input string tag, input logic [63:0] pc);
      lookup_pc = pc;
      #1;
      check(tag, lookup_taken, tbl[idx_of(pc)] >= 2);
   endtask

   // Entered shortly after a negedge with the unit idle; leaves it the same way.
   task automatic resolve(input logic [63:0] pc, input logic taken, input logic pred,
                          input logic [63:0] target);
      int          k;
      int          wait_cyc;
      logic        exp_flush;
      logic [63:0] exp_redir;
      wait_cyc = 0;
      while (!res_ready && wait_cyc < 8) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("ready_idle", res_ready, 1'b1);
      res_pc         = pc;
      res_taken      = taken;
      res_pred_taken = pred;
      res_target     = target;
      res_valid      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_valid = 1'b0;
      k         = idx_of(pc);
      exp_flush = (taken != pred);
      exp_redir = taken ? target : pc + 64'd4;
      if (exp_bc < 64'hFFFF_FFFF) exp_bc++;
      check("ready_update", res_ready, 1'b0);
      check("flush_update", flush, exp_flush);
      if (exp_flush) check("redirect_pc", redirect_pc, exp_redir);
      check("branch_count", branch_count, exp_bc);
      check_lookup("lookup_before_write", pc);
      @(posedge clk);
      if (taken) tbl[k] = (tbl[k] < 3) ? tbl[k] + 1 : 3;
      else       tbl[k] = (tbl[k] > 0) ? tbl[k] - 1 : 0;
      if (exp_flush && exp_mc < 64'hFFFF_FFFF) exp_mc++;
      @(negedge clk);
      check("flush_clear", flush, 1'b0);
      check("mispredict_count", mispredict_count, exp_mc);
      check_lookup("lookup_after_write", pc);
      check_lookup("lookup_other", {$urandom, $urandom});
   endtask

   initial begin
      rst            = 1'b1;
      res_valid      = 1'b0;
      res_pc         = '0;
      res_taken      = 1'b0;
      res_pred_taken = 1'b0;
      res_target     = '0;
      lookup_pc      = 64'h100;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_lookup", lookup_taken, 1'b0);
      check("rst_ready", res_ready, 1'b0);
      check("rst_flush", flush, 1'b0);
      check("rst_redirect", redirect_pc, 64'h0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", res_ready, 1'b1);
      check("rst_branch_count", branch_count, 32'd0);
      check("rst_mispredict_count", mispredict_count, 32'd0);

      // Directed scenarios.
      resolve(64'h100, 1'b1, 1'b0, 64'h200);
      resolve(64'h104, 1'b0, 1'b0, 64'h300);
      resolve(64'h104, 1'b0, 1'b0, 64'h300);
      resolve(64'h108, 1'b0, 1'b1, 64'h500);
      resolve(64'h000, 1'b1, 1'b1, 64'h040);
      resolve(64'h100, 1'b1, 1'b1, 64'h080);
      resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 64'h0);

      // Reset while a mispredict is in UPDATE.
      res_pc         = 64'h10;
      res_taken      = 1'b1;
      res_pred_taken = 1'b0;
      res_target     = 64'h900;
      res_valid      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_valid = 1'b0;
      rst       = 1'b1;
      #1;
      check("rst_in_update_flush", flush, 1'b0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      check("rst_in_update_flush_after", flush, 1'b0);
      check("rst_in_update_bc", branch_count, 32'd0);
      check("rst_in_update_mc", mispredict_count, 32'd0);
      check_lookup("rst_in_update_entry", 64'h10);
      rst = 1'b0;
      #1;
      check("ready_after_rst2", res_ready, 1'b1);
      resolve(64'h10, 1'b1, 1'b0, 64'h900);

      // Random resolutions, biased toward a few indices to exercise saturation.
      for (int n = 0; n < 300; n++) begin
         logic [63:0] pc;
         if ($urandom_range(0, 1) == 0) pc = {$urandom, $urandom_range(0, 7), 2'b00};
         else                           pc = {$urandom, $urandom};
         resolve(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Absolute time bound so a stuck run still terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
